// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: pin synchroniser and clock deglitcher, 11-bit frame
// deserialiser, show-ahead scancode FIFO and sticky error flags for the ZPU bus.
module ps2_keyboard_rx #(
  parameter int sysclk_frequency = 1330,
  parameter int filter_len       = 8,
  parameter int fifo_depth_log2  = 4
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rd_data,
  output logic       empty,
  input  logic       rd_en,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clear_err,
  output logic       busy
);

  localparam int timeout_cycles = sysclk_frequency * 10;
  localparam int to_w           = $clog2(timeout_cycles + 1);
  localparam int depth          = 1 << fifo_depth_log2;
  localparam int aw             = fifo_depth_log2;

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_data   = 2'd1;
  localparam logic [1:0] st_parity = 2'd2;
  localparam logic [1:0] st_stop   = 2'd3;

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [filter_len-1:0] clk_hist;
  logic                  clk_filt;
  logic                  fall;
  logic                  dat_bit;

  logic [1:0]            state;
  logic [2:0]            bitcnt;
  logic [7:0]            shreg;
  logic                  par_bit;
  logic [to_w-1:0]       to_cnt;
  logic                  timeout;

  logic                  start_err;
  logic                  stop_err;
  logic                  par_bad;
  logic                  push;

  logic [7:0]            mem [depth];
  logic [aw:0]           wr_ptr;
  logic [aw:0]           rd_ptr;
  logic                  full;
  logic                  pop;
  logic                  wr;

  // A falling edge is the cycle in which the filtered clock is about to drop to 0.
  assign fall    = clk_filt && (clk_hist == '0);
  assign dat_bit = dat_sync[1];

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_hist <= '1;
      clk_filt <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples pre-edge values.
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_hist <= {clk_hist[filter_len-2:0], clk_sync[1]};
      if (&clk_hist)
        clk_filt <= 1'b1;
      else if (clk_hist == '0)
        clk_filt <= 1'b0;
    end
  end

  assign busy    = (state != st_idle);
  assign timeout = busy && !fall && (to_cnt == to_w'(timeout_cycles - 1));

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state   <= st_idle;
      bitcnt  <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (!busy || fall)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        state <= st_idle;
      end else if (fall) begin
        case (state)
          st_idle: begin
            if (!dat_bit) begin
              state  <= st_data;
              bitcnt <= 3'd0;
            end
          end
          st_data: begin
            shreg  <= {dat_bit, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7)
              state <= st_parity;
          end
          st_parity: begin
            par_bit <= dat_bit;
            state   <= st_stop;
          end
          default: state <= st_idle;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    start_err = 1'b0;
    stop_err  = 1'b0;
    par_bad   = 1'b0;
    push      = 1'b0;
    if (fall) begin
      case (state)
        st_idle: start_err = dat_bit;
        st_stop: begin
          stop_err = !dat_bit;
          par_bad  = dat_bit && !(^{shreg, par_bit});
          push     = dat_bit &&  (^{shreg, par_bit});
        end
        default: ;
      endcase
    end
  end

  // Pointers carry one extra wrap bit so full and empty differ.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign pop   = rd_en && !empty;
  assign wr    = push && (!full || pop);

  assign rd_data = empty ? 8'h00 : mem[rd_ptr[aw-1:0]];

  // NOTE: the storage array is deliberately not reset; rd_data is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr[aw-1:0]] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky flags: a new error in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (par_bad)
        parity_err <= 1'b1;
      else if (clear_err)
        parity_err <= 1'b0;

      if (start_err || stop_err || timeout)
        frame_err <= 1'b1;
      else if (clear_err)
        frame_err <= 1'b0;

      if (push && full && !pop)
        overflow <= 1'b1;
      else if (clear_err)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: scoreboard queue of expected scancodes
// filled as frames are sent and drained as the FIFO is read.
module tb_ps2_keyboard_rx;

  localparam int half_bit = 40;
  localparam int depth    = 16;
  localparam int exp_lat  = 2 + 8 + 1;

  logic       clk       = 1'b0;
  logic       reset_in  = 1'b0;
  logic       ps2_clk   = 1'b1;
  logic       ps2_dat   = 1'b1;
  logic       rd_en     = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];

  ps2_keyboard_rx #(
    .sysclk_frequency(1330),
    .filter_len      (8),
    .fifo_depth_log2 (4)
  ) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rd_data   (rd_data),
    .empty     (empty),
    .rd_en     (rd_en),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clear_err (clear_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cycles(half_bit / 2);
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(half_bit - half_bit / 2 - 3);
    end else begin
      wait_cycles(half_bit);
    end
    ps2_clk = 1'b0;
    wait_cycles(half_bit);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic par;
    par = ~(^b) ^ bad_par;
    if (!bad_par && !bad_stop && exp_q.size() < depth)
      exp_q.push_back(b);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++)
      send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(!bad_stop, glitch);
    ps2_dat = 1'b1;
    wait_cycles(half_bit);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check(input string name);
    logic [7:0] exp;
    exp = 8'h00;
    if (exp_q.size() > 0)
      exp = exp_q.pop_front();
    total_cnt++;
    if (empty !== 1'b0 || rd_data !== exp)
      $display("FAIL %s: empty=%b rd_data=%h, expected empty=0 rd_data=%h", name, empty, rd_data, exp);
    else
      pass_cnt++;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    wait_cycles(4);
    total_cnt++;
    if ({empty, busy, parity_err, frame_err, overflow, rd_data} !== {5'b10000, 8'h00})
      $display("FAIL reset_state: got %b expected %b",
               {empty, busy, parity_err, frame_err, overflow, rd_data}, {5'b10000, 8'h00});
    else
      pass_cnt++;
    reset_in = 1'b1;
    wait_cycles(100);
    total_cnt++;
    if ({empty, busy, parity_err, frame_err, overflow} !== 5'b10000)
      $display("FAIL idle_line: got %b expected %b",
               {empty, busy, parity_err, frame_err, overflow}, 5'b10000);
    else
      pass_cnt++;
  endtask

  task automatic test_basic_latency();
    logic [7:0] b;
    int         lat;
    b = 8'h1C;
    exp_q.push_back(b);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      send_bit(b[i], 1'b0);
    send_bit(1'b0, 1'b0);
    ps2_dat = 1'b1;
    wait_cycles(half_bit);
    ps2_clk = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      #1;
      if (!empty)
        break;
    end
    total_cnt++;
    if (lat !== exp_lat)
      $display("FAIL push_latency: got %0d cycles expected %0d", lat, exp_lat);
    else
      pass_cnt++;
    @(negedge clk);
    wait_cycles(half_bit);
    ps2_clk = 1'b1;
    wait_cycles(half_bit);
    read_check("basic_1c");
    total_cnt++;
    if ({empty, parity_err, frame_err, overflow} !== 4'b1000)
      $display("FAIL basic_after_pop: got %b expected %b",
               {empty, parity_err, frame_err, overflow}, 4'b1000);
    else
      pass_cnt++;
  endtask

  task automatic test_parity();
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if ({empty, parity_err, frame_err} !== 3'b110)
      $display("FAIL parity_error: got %b expected %b", {empty, parity_err, frame_err}, 3'b110);
    else
      pass_cnt++;
    pulse_clear();
    total_cnt++;
    if (parity_err !== 1'b0)
      $display("FAIL parity_clear: got %b expected 0", parity_err);
    else
      pass_cnt++;
  endtask

  task automatic test_bad_stop();
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if ({empty, parity_err, frame_err} !== 3'b101)
      $display("FAIL bad_stop: got %b expected %b", {empty, parity_err, frame_err}, 3'b101);
    else
      pass_cnt++;
    pulse_clear();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < depth; i++)
      send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (overflow !== 1'b0)
      $display("FAIL full_no_overflow: got %b expected 0", overflow);
    else
      pass_cnt++;
    send_frame(8'h10, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({overflow, parity_err, frame_err} !== 3'b100)
      $display("FAIL overflow_set: got %b expected %b", {overflow, parity_err, frame_err}, 3'b100);
    else
      pass_cnt++;
    for (int i = 0; i < depth; i++)
      read_check("overflow_drain");
    total_cnt++;
    if (empty !== 1'b1)
      $display("FAIL drained_empty: got %b expected 1", empty);
    else
      pass_cnt++;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    pulse_clear();
    total_cnt++;
    if ({empty, overflow} !== 2'b10)
      $display("FAIL pop_when_empty: got %b expected %b", {empty, overflow}, 2'b10);
    else
      pass_cnt++;
  endtask

  task automatic test_timeout();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1, 1'b0);
    wait_cycles(12800);
    total_cnt++;
    if ({busy, frame_err} !== 2'b10)
      $display("FAIL before_timeout: got %b expected %b", {busy, frame_err}, 2'b10);
    else
      pass_cnt++;
    wait_cycles(600);
    total_cnt++;
    if ({busy, frame_err, empty} !== 3'b011)
      $display("FAIL after_timeout: got %b expected %b", {busy, frame_err, empty}, 3'b011);
    else
      pass_cnt++;
    pulse_clear();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    read_check("after_timeout_5a");
  endtask

  task automatic test_glitch();
    send_frame(8'hA7, 1'b0, 1'b0, 1'b1);
    read_check("glitch_a7");
    total_cnt++;
    if ({parity_err, frame_err, overflow, empty} !== 4'b0001)
      $display("FAIL glitch_flags: got %b expected %b",
               {parity_err, frame_err, overflow, empty}, 4'b0001);
    else
      pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    total_cnt++;
    if ({busy, empty, parity_err} !== 3'b101)
      $display("FAIL before_reset: got %b expected %b", {busy, empty, parity_err}, 3'b101);
    else
      pass_cnt++;
    @(posedge clk);
    #2;
    reset_in = 1'b0;
    #1;
    total_cnt++;
    if ({empty, busy, parity_err, frame_err, overflow, rd_data} !== {5'b10000, 8'h00})
      $display("FAIL async_reset: got %b expected %b",
               {empty, busy, parity_err, frame_err, overflow, rd_data}, {5'b10000, 8'h00});
    else
      pass_cnt++;
    exp_q.delete();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cycles(3);
    reset_in = 1'b1;
    wait_cycles(50);
    total_cnt++;
    if ({empty, busy, parity_err, frame_err, overflow} !== 5'b10000)
      $display("FAIL after_reset_idle: got %b expected %b",
               {empty, busy, parity_err, frame_err, overflow}, 5'b10000);
    else
      pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_parity();
    test_bad_stop();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 device-to-host receiver placed upstream of the ZPU system block.
- Synchronises and deglitches the board's PS2_CLK/PS2_DAT pins.
- Deserialises 11-bit frames and checks parity and stop bit.
- Queues good scancodes in a show-ahead FIFO that the ZPU peripheral bus drains through a read strobe.
- Sticky error flags report bad frames and FIFO overflow to software.

Parameters:
sysclk_frequency, 1330, system clock in units of 100 kHz (1330 = 133 MHz); sets the inter-edge timeout.
filter_len, 8, number of consecutive equal samples needed before the filtered PS/2 clock changes level (2..16).
fifo_depth_log2, 4, FIFO depth = 2^fifo_depth_log2 entries.

Ports:
clk  in  1  system clock (clk133 domain)
reset_in  in  1  asynchronous reset, active-low
ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk
ps2_dat  in  1  raw PS/2 data pin, asynchronous to clk
rd_data  out  8  FIFO head scancode, valid while empty=0
empty  out  1  FIFO empty
rd_en  in  1  pop strobe, one entry per cycle high
parity_err  out  1  sticky: frame discarded for bad odd parity
frame_err  out  1  sticky: bad start/stop bit or timeout mid-frame
overflow  out  1  sticky: good byte dropped because FIFO full
clear_err  in  1  clears all three sticky flags
busy  out  1  receiver is mid-frame

Behaviour:
- Reset (reset_in=0, async): FSM=IDLE; FIFO pointers=0; empty=1; rd_data=0; all error flags=0; busy=0; filter history all-ones; filtered clock=1.
- Input path: 2-flop synchroniser on each pin. The filtered clock takes a new level only after filter_len consecutive identical synchronised samples. A falling edge is a filtered 1->0 transition. Data is sampled from the synchronised ps2_dat in the same cycle as that edge.
- FSM, advancing only on falling edges:
  - IDLE: data=0 -> DATA with bitcnt=0. data=1 -> frame_err=1, stay IDLE.
  - DATA: shift data in LSB first; after bit 7 -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: accept the byte if stop=1 and the XOR of the 8 data bits and parity bit is 1. On stop=0 set frame_err. On bad parity with stop=1 set parity_err. Always return to IDLE.
- busy=1 in every state except IDLE.
- Timeout: a counter is cleared on each falling edge and counts while the FSM is not IDLE. At sysclk_frequency*10 cycles (100 us), FSM->IDLE, the partial byte is discarded and frame_err=1.
- Push: an accepted byte is written at the clock edge that completes STOP; empty=0 from the next cycle. Total latency, stop-bit pin fall to empty=0, is 2 sync + filter_len + 1 cycles.
- FIFO is show-ahead:
  - rd_data always shows the head entry.
  - rd_en with empty=0 pops; the new head appears next cycle.
  - rd_en while empty=1 is ignored: no pointer change, no error.
- Full FIFO and push with no pop in the same cycle: byte dropped, overflow=1, contents unchanged.
- Full FIFO with push and pop in the same cycle: both are performed, occupancy unchanged, no overflow.
- Pointers are fifo_depth_log2+1 bits wide so full and empty are distinguishable; they wrap naturally.
- Sticky flags: clear_err clears all three at the next edge. If clear_err and a new error occur in the same cycle, set wins.
- Line idle high and stable: no state change, no flags.

Test Plan:
- Send frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> rd_data=0x1C, empty=0 within 2+8+1 cycles of the stop-bit fall; pulse rd_en -> empty=1; no flags set.
- Send 0xF0 with parity forced to 1 -> FIFO stays empty; parity_err=1. Then pulse clear_err -> parity_err=0.
- Send 17 good bytes 0x00..0x10 with no reads (depth 16) -> overflow=1. Reads return 0x00..0x0F in order, then empty=1.
- Abort a frame after 4 data bits and hold the clock high for 13300+ cycles -> frame_err=1, busy=0, FIFO unchanged. A following good 0x5A is then received correctly.
- Inject 3-cycle low glitches on ps2_clk between real edges -> received byte is unchanged and no error flags are set.
- Assert reset_in=0 mid-frame with 2 bytes queued -> empty=1, busy=0 and flags 0 immediately, without waiting for a clock edge.
